// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: boot delay, sequential/jump/branch selection, load-use stall and stall watchdog.
// Optional macro PC_ALIGN_CHECK_EN: force redirect targets word-aligned and flag misaligned ones.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned MAX_STALL   = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        hd_i,
  input  logic        branch_i,
  input  logic [31:0] branch_tgt_i,
  input  logic        jump_i,
  input  logic [31:0] jump_tgt_i,
  output logic [31:0] pc_o,
  output logic        pc_we_o,
  output logic        ifid_we_o,
  output logic        ifid_flush_o,
  output logic        running_o,
  output logic        stall_err_o,
  output logic        align_err_o
);

  localparam int unsigned PC_W  = 32;
  localparam int unsigned BCW   = 4;
  localparam int unsigned SCW   = 8;
  localparam logic [BCW-1:0] BOOT_LAST = BCW'(BOOT_CYCLES - 1);
  localparam logic [SCW-1:0] STALL_MAX = SCW'(MAX_STALL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BOOT  = 2'd1,
    RUN   = 2'd2,
    STALL = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [BCW-1:0]  boot_cnt_q, boot_cnt_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [SCW-1:0]  stall_cnt_q, stall_cnt_d;
  logic            stall_err_q, stall_err_d;
  logic            running_q;
  logic            redirect;
  logic [PC_W-1:0] tgt_raw, tgt;

  // Jump wins over branch when both are asserted.
  assign tgt_raw = jump_i ? jump_tgt_i : branch_tgt_i;

`ifdef PC_ALIGN_CHECK_EN
  logic align_err_q;
  assign tgt         = {tgt_raw[PC_W-1:2], 2'b00};
  assign align_err_o = align_err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) align_err_q <= 1'b0;
    else if (redirect && (tgt_raw[1:0] != 2'b00)) align_err_q <= 1'b1;
  end
`else
  assign tgt         = tgt_raw;
  assign align_err_o = 1'b0;
`endif

  // Next-state, next-PC, watchdog and combinational enables.
  always_comb begin
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    pc_d         = pc_q;
    stall_cnt_d  = stall_cnt_q;
    pc_we_o      = 1'b0;
    ifid_we_o    = 1'b0;
    ifid_flush_o = 1'b0;
    redirect     = 1'b0;
    if (start_i) begin
      case (state_q)
        IDLE: begin
          ifid_flush_o = 1'b1;
          state_d      = BOOT;
          boot_cnt_d   = '0;
        end
        BOOT: begin
          ifid_flush_o = 1'b1;
          if (boot_cnt_q == BOOT_LAST) state_d = RUN;
          else boot_cnt_d = boot_cnt_q + BCW'(1);
        end
        RUN, STALL: begin
          if (hd_i) begin
            // ID instruction is re-presented, so any redirect now is ignored.
            state_d = STALL;
            if (stall_cnt_q < STALL_MAX) stall_cnt_d = stall_cnt_q + SCW'(1);
          end else begin
            state_d     = RUN;
            stall_cnt_d = '0;
            pc_we_o     = 1'b1;
            if (jump_i || branch_i) begin
              redirect     = 1'b1;
              pc_d         = tgt;
              ifid_flush_o = 1'b1;
            end else begin
              pc_d      = pc_q + PC_W'(4);
              ifid_we_o = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    stall_err_d = stall_err_q | (stall_cnt_d == STALL_MAX);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      boot_cnt_q  <= '0;
      pc_q        <= RESET_PC;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
      running_q   <= (state_d == RUN) || (state_d == STALL);
    end
  end

  assign pc_o        = pc_q;
  assign running_o   = running_q;
  assign stall_err_o = stall_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (BOOT_CYCLES=2, MAX_STALL=3); align expectations follow PC_ALIGN_CHECK_EN.
module tb_pc_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        hd_i;
  logic        branch_i;
  logic [31:0] branch_tgt_i;
  logic        jump_i;
  logic [31:0] jump_tgt_i;
  logic [31:0] pc_o;
  logic        pc_we_o;
  logic        ifid_we_o;
  logic        ifid_flush_o;
  logic        running_o;
  logic        stall_err_o;
  logic        align_err_o;

  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer #(
    .RESET_PC   (32'h0000_0000),
    .BOOT_CYCLES(2),
    .MAX_STALL  (3)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .hd_i        (hd_i),
    .branch_i    (branch_i),
    .branch_tgt_i(branch_tgt_i),
    .jump_i      (jump_i),
    .jump_tgt_i  (jump_tgt_i),
    .pc_o        (pc_o),
    .pc_we_o     (pc_we_o),
    .ifid_we_o   (ifid_we_o),
    .ifid_flush_o(ifid_flush_o),
    .running_o   (running_o),
    .stall_err_o (stall_err_o),
    .align_err_o (align_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_en(input string tag, input logic pc_we, input logic ifid_we, input logic flush);
    chk({tag, ".pc_we"}, 32'(pc_we_o), 32'(pc_we));
    chk({tag, ".ifid_we"}, 32'(ifid_we_o), 32'(ifid_we));
    chk({tag, ".flush"}, 32'(ifid_flush_o), 32'(flush));
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b1; hd_i = 1'b0;
    branch_i = 1'b0; branch_tgt_i = '0; jump_i = 1'b0; jump_tgt_i = '0;
    #3;
    chk("rst.pc", pc_o, 32'h0);
    chk("rst.running", 32'(running_o), 32'h0);
    chk("rst.stall_err", 32'(stall_err_o), 32'h0);
    chk("rst.align_err", 32'(align_err_o), 32'h0);
    chk_en("rst", 1'b0, 1'b0, 1'b1);
    rst_i = 1'b1;

    // Boot: IDLE->BOOT, two BOOT cycles, then sequential fetch
    tick(); chk("boot1.pc", pc_o, 32'h0); chk_en("boot1", 1'b0, 1'b0, 1'b1);
    chk("boot1.running", 32'(running_o), 32'h0);
    tick(); chk("boot2.pc", pc_o, 32'h0); chk_en("boot2", 1'b0, 1'b0, 1'b1);
    tick(); chk("run0.pc", pc_o, 32'h0); chk_en("run0", 1'b1, 1'b1, 1'b0);
    chk("run0.running", 32'(running_o), 32'h1);
    tick(); chk("run1.pc", pc_o, 32'h4);
    tick(); chk("run2.pc", pc_o, 32'h8);
    tick(); tick(); chk("run4.pc", pc_o, 32'h10);

    // Load-use stall with a simultaneous branch
    hd_i = 1'b1; branch_i = 1'b1; branch_tgt_i = 32'h100;
    #1 chk_en("stall", 1'b0, 1'b0, 1'b0);
    tick(); chk("stall1.pc", pc_o, 32'h10); chk("stall1.running", 32'(running_o), 32'h1);
    tick(); chk("stall2.pc", pc_o, 32'h10); chk("stall2.err", 32'(stall_err_o), 32'h0);
    hd_i = 1'b0; branch_i = 1'b0;
    tick(); chk("unstall.pc", pc_o, 32'h14);

    // Jump beats branch; flush for exactly one cycle
    jump_i = 1'b1; jump_tgt_i = 32'h200; branch_i = 1'b1; branch_tgt_i = 32'h100;
    #1 chk_en("redir", 1'b1, 1'b0, 1'b1);
    tick(); chk("redir.pc", pc_o, 32'h200);
    jump_i = 1'b0; branch_i = 1'b0;
    #1 chk_en("postredir", 1'b1, 1'b1, 1'b0);
    tick(); chk("postredir.pc", pc_o, 32'h204);

    // Pause mid-RUN
    start_i = 1'b0;
    #1 chk_en("pause", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pause.pc", pc_o, 32'h204);
      chk("pause.running", 32'(running_o), 32'h1);
    end
    start_i = 1'b1;
    #1 chk_en("resume", 1'b1, 1'b1, 1'b0);
    tick(); chk("resume.pc", pc_o, 32'h208);

    // Watchdog trips on the third consecutive stall edge, then stays set
    hd_i = 1'b1;
    tick(); chk("wd1.err", 32'(stall_err_o), 32'h0);
    tick(); chk("wd2.err", 32'(stall_err_o), 32'h0);
    tick(); chk("wd3.err", 32'(stall_err_o), 32'h1); chk("wd3.pc", pc_o, 32'h208);
    hd_i = 1'b0;
    tick(); chk("wd4.err", 32'(stall_err_o), 32'h1); chk("wd4.pc", pc_o, 32'h20C);

    // Wrap from the top of the address space
    jump_i = 1'b1; jump_tgt_i = 32'hFFFF_FFFC;
    tick(); chk("wrap0.pc", pc_o, 32'hFFFF_FFFC);
    jump_i = 1'b0;
    tick(); chk("wrap1.pc", pc_o, 32'h0);
    tick(); chk("wrap2.pc", pc_o, 32'h4);

    // Misaligned branch target
    branch_i = 1'b1; branch_tgt_i = 32'h103;
    tick();
`ifdef PC_ALIGN_CHECK_EN
    chk("align.pc", pc_o, 32'h100);
    chk("align.err", 32'(align_err_o), 32'h1);
`else
    chk("align.pc", pc_o, 32'h103);
    chk("align.err", 32'(align_err_o), 32'h0);
`endif
    branch_i = 1'b0;

    // Async reset mid-RUN with a redirect pending
    jump_i = 1'b1; jump_tgt_i = 32'h300;
    #2 rst_i = 1'b0;
    #1;
    chk("arst.pc", pc_o, 32'h0);
    chk("arst.running", 32'(running_o), 32'h0);
    chk("arst.stall_err", 32'(stall_err_o), 32'h0);
    chk("arst.align_err", 32'(align_err_o), 32'h0);
    chk_en("arst", 1'b0, 1'b0, 1'b1);
    tick(); chk("arst_hold.pc", pc_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
